motor_drive: RTL and testbench
==============================

Name: motor_drive

Overview:
- Downstream stage of the line-tracker policy block. Consumes its 2-bit steering command: 00 turn_left, 01 turn_right, 10 go_straight, 11 stop.
- Produces per-wheel PWM enables and direction pins for the motor H-bridge.
- Filters short command glitches, ramps wheel duty to limit current spikes and wheel slip, and updates PWM duty only on period boundaries. Stop is the exception and takes effect immediately.

Parameters:
PWM_BITS, 10, PWM counter/duty width; PWM period = 2^PWM_BITS clk cycles
DUTY_FAST, 800, duty for outer wheel / straight driving
DUTY_SLOW, 400, duty for inner wheel during a turn
RAMP_STEP, 16, duty change per ramp tick
RAMP_DIV, 1000, clk cycles between ramp ticks
HOLD_CYCLES, 16, cycles a non-stop command must be stable before acceptance (>=2)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
state  input  2  steering command from tracker policy
pwm_left  output  1  left motor enable PWM
pwm_right  output  1  right motor enable PWM
dir_left  output  2  left H-bridge inputs: 2'b10 forward, 2'b00 coast
dir_right  output  2  right H-bridge inputs, same encoding
cmd  output  2  currently accepted command
moving  output  1  high when either applied duty is nonzero

Behaviour:
- Interface: reset reset, synchronous, active-high; clock clk. All outputs registered.
- Reset values:
  - cmd=2'b11, pwm_*=0, dir_*=2'b00, moving=0.
  - Internal state cleared: duty, applied duty, PWM counter, ramp counter, hold counter.
  - prev_in is cleared to 2'b11.
- Command filter:
  - prev_in <= state every cycle.
  - If state != prev_in, hold_cnt <= 0.
  - Else hold_cnt increments, saturating at HOLD_CYCLES-1.
  - When hold_cnt == HOLD_CYCLES-1, state == prev_in and state != cmd: cmd <= state.
  - Result: a stable non-stop input is accepted on the (HOLD_CYCLES+1)th rising edge after it first appears. Shorter pulses are ignored.
- Stop bypass:
  - When state == 2'b11, on the next edge: cmd <= 11, duty_left/right <= 0, applied duty <= 0.
  - No filtering, no ramp, no period wait.
- Targets by cmd:
  - 10: L=FAST, R=FAST.
  - 00: L=SLOW, R=FAST.
  - 01: L=FAST, R=SLOW.
  - 11: both 0.
- Ramp:
  - ramp_cnt counts 0..RAMP_DIV-1 and wraps; tick when ramp_cnt == RAMP_DIV-1.
  - On tick, per wheel: duty < target gives duty <= min(duty+RAMP_STEP, target); duty > target gives duty <= max(duty-RAMP_STEP, target).
  - Arithmetic is PWM_BITS+1 wide; never wraps or underflows.
- PWM:
  - pwm_cnt free-runs 0..2^PWM_BITS-1.
  - When pwm_cnt == 2^PWM_BITS-1, applied_* <= duty_*. Stop bypass is the only other update.
  - pwm_* <= (pwm_cnt < applied_*), so high for applied_* cycles per period.
  - applied 0 gives pwm constantly low.
- Direction and status: dir_* <= (applied_* != 0) ? 2'b10 : 2'b00. moving <= (applied_left | applied_right) != 0.
- Simultaneous events:
  - Stop bypass overrides a ramp tick and a period-boundary latch in the same cycle.
  - A ramp tick and a boundary latch in the same cycle: the latch takes the pre-tick duty.
- Reset mid-operation: everything returns to reset values on that edge regardless of ramp or PWM phase.

Test Plan:
Bench overrides: PWM_BITS=4, DUTY_FAST=12, DUTY_SLOW=6, RAMP_STEP=4, RAMP_DIV=4, HOLD_CYCLES=4.
- Reset held 3 cycles with state=10 -> cmd=11, pwm_*=0, dir_*=00, moving=0 throughout.
- state=10 from cycle 0 -> cmd=10 after 5th edge; duty_left/right step 4,8,12 on successive ticks (every 4 cycles), then stay 12. applied_* changes only when pwm_cnt==15. At steady state pwm_* high exactly 12 of every 16 cycles, dir_*=10, moving=1.
- Glitch: state 11->10 for 3 cycles ->11 -> cmd stays 11, pwm never asserts.
- From steady straight (both 12), state=00 held -> cmd=00 after 5 edges; left duty 12->8->6 on ticks and holds at 6, right stays 12. Left PWM high 6/16 after next period boundary.
- From steady straight, state=11 at arbitrary pwm_cnt (e.g. 5) -> next edge cmd=11, applied_*=0; pwm_* low and dir_*=00 by second edge; moving=0.
- Reset asserted mid-ramp (duty=8) -> next edge all outputs at reset values. After release with state=10, the ramp restarts from 0.

Source files
------------

// File: rtl/motor_drive.sv
// Wheel drive for the line tracker: debounces the steering command, ramps per-wheel
// duty toward the command's targets and emits period-aligned PWM plus H-bridge pins.
module motor_drive #(
  parameter int unsigned PWM_BITS    = 10,
  parameter int unsigned DUTY_FAST   = 800,
  parameter int unsigned DUTY_SLOW   = 400,
  parameter int unsigned RAMP_STEP   = 16,
  parameter int unsigned RAMP_DIV    = 1000,
  parameter int unsigned HOLD_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] state,
  output logic       pwm_left,
  output logic       pwm_right,
  output logic [1:0] dir_left,
  output logic [1:0] dir_right,
  output logic [1:0] cmd,
  output logic       moving
);

  localparam int unsigned WIDE   = PWM_BITS + 1;
  localparam int unsigned HOLD_W = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;
  localparam int unsigned RAMP_W = (RAMP_DIV > 2) ? $clog2(RAMP_DIV) : 1;

  localparam logic [1:0] CMD_LEFT     = 2'b00;
  localparam logic [1:0] CMD_RIGHT    = 2'b01;
  localparam logic [1:0] CMD_STRAIGHT = 2'b10;
  localparam logic [1:0] CMD_STOP     = 2'b11;

  localparam logic [1:0] DIR_FWD   = 2'b10;
  localparam logic [1:0] DIR_COAST = 2'b00;

  localparam logic [PWM_BITS-1:0] FAST     = PWM_BITS'(DUTY_FAST);
  localparam logic [PWM_BITS-1:0] SLOW     = PWM_BITS'(DUTY_SLOW);
  localparam logic [PWM_BITS-1:0] PWM_LAST = '1;
  localparam logic [WIDE-1:0]     STEP     = WIDE'(RAMP_STEP);
  localparam logic [HOLD_W-1:0]   HOLD_MAX = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [RAMP_W-1:0]   RAMP_MAX = RAMP_W'(RAMP_DIV - 1);

  logic [1:0]          prev_in, prev_in_nxt;
  logic [HOLD_W-1:0]   hold_cnt, hold_cnt_nxt;
  logic [1:0]          cmd_nxt;
  logic [RAMP_W-1:0]   ramp_cnt, ramp_cnt_nxt;
  logic [PWM_BITS-1:0] pwm_cnt, pwm_cnt_nxt;
  logic [PWM_BITS-1:0] duty_left, duty_left_nxt;
  logic [PWM_BITS-1:0] duty_right, duty_right_nxt;
  logic [PWM_BITS-1:0] applied_left, applied_left_nxt;
  logic [PWM_BITS-1:0] applied_right, applied_right_nxt;
  logic [PWM_BITS-1:0] target_left, target_right;
  logic                stop, accept, ramp_tick, boundary;
  logic                pwm_left_nxt, pwm_right_nxt, moving_nxt;
  logic [1:0]          dir_left_nxt, dir_right_nxt;

  // One ramp step toward tgt, computed one bit wider so it cannot wrap or underflow.
  function automatic logic [PWM_BITS-1:0] ramp_toward(input logic [PWM_BITS-1:0] cur,
                                                      input logic [PWM_BITS-1:0] tgt);
    logic [WIDE-1:0] cur_w;
    logic [WIDE-1:0] tgt_w;
    cur_w = {1'b0, cur};
    tgt_w = {1'b0, tgt};
    ramp_toward = cur;
    if (cur_w < tgt_w) begin
      if ((tgt_w - cur_w) <= STEP) ramp_toward = tgt;
      else                         ramp_toward = PWM_BITS'(cur_w + STEP);
    end else if (cur_w > tgt_w) begin
      if ((cur_w - tgt_w) <= STEP) ramp_toward = tgt;
      else                         ramp_toward = PWM_BITS'(cur_w - STEP);
    end
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_in       <= CMD_STOP;
      hold_cnt      <= '0;
      cmd           <= CMD_STOP;
      ramp_cnt      <= '0;
      pwm_cnt       <= '0;
      duty_left     <= '0;
      duty_right    <= '0;
      applied_left  <= '0;
      applied_right <= '0;
      pwm_left      <= 1'b0;
      pwm_right     <= 1'b0;
      dir_left      <= DIR_COAST;
      dir_right     <= DIR_COAST;
      moving        <= 1'b0;
    end else begin
      prev_in       <= prev_in_nxt;
      hold_cnt      <= hold_cnt_nxt;
      cmd           <= cmd_nxt;
      ramp_cnt      <= ramp_cnt_nxt;
      pwm_cnt       <= pwm_cnt_nxt;
      duty_left     <= duty_left_nxt;
      duty_right    <= duty_right_nxt;
      applied_left  <= applied_left_nxt;
      applied_right <= applied_right_nxt;
      pwm_left      <= pwm_left_nxt;
      pwm_right     <= pwm_right_nxt;
      dir_left      <= dir_left_nxt;
      dir_right     <= dir_right_nxt;
      moving        <= moving_nxt;
    end
  end

  // Command filter, ramp and period-boundary duty latch; stop overrides everything.
  always_comb begin
    prev_in_nxt       = state;
    hold_cnt_nxt      = hold_cnt;
    cmd_nxt           = cmd;
    ramp_cnt_nxt      = ramp_cnt + RAMP_W'(1);
    pwm_cnt_nxt       = pwm_cnt + PWM_BITS'(1);
    duty_left_nxt     = duty_left;
    duty_right_nxt    = duty_right;
    applied_left_nxt  = applied_left;
    applied_right_nxt = applied_right;
    target_left       = '0;
    target_right      = '0;

    stop      = (state == CMD_STOP);
    accept    = (hold_cnt == HOLD_MAX) && (state == prev_in) && (state != cmd);
    ramp_tick = (ramp_cnt == RAMP_MAX);
    boundary  = (pwm_cnt == PWM_LAST);

    if (state != prev_in)        hold_cnt_nxt = '0;
    else if (hold_cnt != HOLD_MAX) hold_cnt_nxt = hold_cnt + HOLD_W'(1);

    if (ramp_tick) ramp_cnt_nxt = '0;

    case (cmd)
      CMD_STRAIGHT: begin target_left = FAST; target_right = FAST; end
      CMD_LEFT:     begin target_left = SLOW; target_right = FAST; end
      CMD_RIGHT:    begin target_left = FAST; target_right = SLOW; end
      default:      begin target_left = '0;   target_right = '0;   end
    endcase

    if (stop) begin
      cmd_nxt           = CMD_STOP;
      duty_left_nxt     = '0;
      duty_right_nxt    = '0;
      applied_left_nxt  = '0;
      applied_right_nxt = '0;
    end else begin
      if (accept) cmd_nxt = state;
      if (ramp_tick) begin
        duty_left_nxt  = ramp_toward(duty_left, target_left);
        duty_right_nxt = ramp_toward(duty_right, target_right);
      end
      // Latch takes the pre-tick duty when a tick lands on the boundary.
      if (boundary) begin
        applied_left_nxt  = duty_left;
        applied_right_nxt = duty_right;
      end
    end
  end

  // Registered pin drive derived from the currently applied duties.
  always_comb begin
    pwm_left_nxt  = (pwm_cnt < applied_left);
    pwm_right_nxt = (pwm_cnt < applied_right);
    dir_left_nxt  = (applied_left != '0) ? DIR_FWD : DIR_COAST;
    dir_right_nxt = (applied_right != '0) ? DIR_FWD : DIR_COAST;
    moving_nxt    = ((applied_left | applied_right) != '0);
  end

endmodule

// File: tb/tb_motor_drive.sv
// Directed bench for motor_drive with small parameters (16-cycle PWM period,
// 4-cycle ramp tick, 4-cycle hold); expected values are hand-computed edge counts.
module tb_motor_drive;

  logic       clk;
  logic       reset;
  logic [1:0] state;
  logic       pwm_left, pwm_right;
  logic [1:0] dir_left, dir_right;
  logic [1:0] cmd;
  logic       moving;

  int n_cmp;
  int n_err;
  int cyc;

  motor_drive #(
    .PWM_BITS(4), .DUTY_FAST(12), .DUTY_SLOW(6),
    .RAMP_STEP(4), .RAMP_DIV(4), .HOLD_CYCLES(4)
  ) dut (
    .clk(clk), .reset(reset), .state(state),
    .pwm_left(pwm_left), .pwm_right(pwm_right),
    .dir_left(dir_left), .dir_right(dir_right),
    .cmd(cmd), .moving(moving)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) tick();
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_cmd"}, 32'(cmd), 32'd3);
    check_eq({tag, "_pwm_l"}, 32'(pwm_left), 32'd0);
    check_eq({tag, "_pwm_r"}, 32'(pwm_right), 32'd0);
    check_eq({tag, "_dir_l"}, 32'(dir_left), 32'd0);
    check_eq({tag, "_dir_r"}, 32'(dir_right), 32'd0);
    check_eq({tag, "_moving"}, 32'(moving), 32'd0);
  endtask

  // Hold reset for three edges with straight requested; edge count restarts at release.
  task automatic do_reset();
    reset = 1'b1;
    state = 2'b10;
    repeat (3) begin
      @(posedge clk);
      #1;
      check_idle("rst");
    end
    reset = 1'b0;
    cyc   = 0;
  endtask

  task automatic count_high(input int n, output int hl, output int hr);
    hl = 0;
    hr = 0;
    repeat (n) begin
      tick();
      hl += int'(pwm_left);
      hr += int'(pwm_right);
    end
  endtask

  // Non-stop pulse of len cycles from stop, then 20 quiet cycles: nothing may move.
  task automatic glitch(input string tag, input int len);
    int bad;
    bad   = 0;
    state = 2'b10;
    repeat (len) begin
      tick();
      if (cmd != 2'b11 || pwm_left || pwm_right || moving) bad++;
    end
    state = 2'b11;
    repeat (20) begin
      tick();
      if (cmd != 2'b11 || pwm_left || pwm_right || moving) bad++;
    end
    check_eq(tag, 32'(bad), 32'd0);
  endtask

  initial begin
    int hl, hr;
    n_cmp = 0;
    n_err = 0;
    cyc   = 0;

    // Reset, then straight: accept on 5th edge, ramp 4/8/12 on edges 8/12/16.
    do_reset();
    run_to(4);  check_eq("str_cmd_e4", 32'(cmd), 32'd3);
    tick();     check_eq("str_cmd_e5", 32'(cmd), 32'd2);
    run_to(7);  check_eq("str_duty_e7", 32'(dut.duty_left), 32'd0);
    tick();     check_eq("str_duty_l_e8", 32'(dut.duty_left), 32'd4);
                check_eq("str_duty_r_e8", 32'(dut.duty_right), 32'd4);
    run_to(12); check_eq("str_duty_e12", 32'(dut.duty_left), 32'd8);
    run_to(16); check_eq("str_duty_e16", 32'(dut.duty_left), 32'd12);
                check_eq("str_applied_e16", 32'(dut.applied_left), 32'd8);
                check_eq("str_moving_e16", 32'(moving), 32'd0);
                check_eq("str_dir_e16", 32'(dir_left), 32'd0);
    count_high(16, hl, hr);
    check_eq("str_high_l_p1", 32'(hl), 32'd8);
    check_eq("str_high_r_p1", 32'(hr), 32'd8);
    count_high(16, hl, hr);
    check_eq("str_high_l_p2", 32'(hl), 32'd12);
    check_eq("str_high_r_p2", 32'(hr), 32'd12);
    check_eq("str_dir_l", 32'(dir_left), 32'd2);
    check_eq("str_dir_r", 32'(dir_right), 32'd2);
    check_eq("str_moving", 32'(moving), 32'd1);

    // Turn left from steady straight.
    state = 2'b00;
    run_to(52); check_eq("turn_cmd_e52", 32'(cmd), 32'd2);
    tick();     check_eq("turn_cmd_e53", 32'(cmd), 32'd0);
    run_to(56); check_eq("turn_duty_l_e56", 32'(dut.duty_left), 32'd8);
                check_eq("turn_duty_r_e56", 32'(dut.duty_right), 32'd12);
    run_to(60); check_eq("turn_duty_l_e60", 32'(dut.duty_left), 32'd6);
    run_to(63); check_eq("turn_applied_e63", 32'(dut.applied_left), 32'd12);
    tick();     check_eq("turn_duty_l_e64", 32'(dut.duty_left), 32'd6);
                check_eq("turn_applied_e64", 32'(dut.applied_left), 32'd6);
    count_high(16, hl, hr);
    check_eq("turn_high_l", 32'(hl), 32'd6);
    check_eq("turn_high_r", 32'(hr), 32'd12);

    // Back to straight, then stop at pwm_cnt 5.
    state = 2'b10;
    run_to(84);  check_eq("back_cmd_e84", 32'(cmd), 32'd0);
    tick();      check_eq("back_cmd_e85", 32'(cmd), 32'd2);
    run_to(92);  check_eq("back_duty_e92", 32'(dut.duty_left), 32'd12);
    run_to(101); check_eq("stop_pre_pwm_l", 32'(pwm_left), 32'd1);
                 check_eq("stop_pre_pwm_r", 32'(pwm_right), 32'd1);
    state = 2'b11;
    tick();
    check_eq("stop_cmd", 32'(cmd), 32'd3);
    check_eq("stop_applied_l", 32'(dut.applied_left), 32'd0);
    check_eq("stop_applied_r", 32'(dut.applied_right), 32'd0);
    check_eq("stop_pwm_lag", 32'(pwm_left), 32'd1);
    check_eq("stop_moving_lag", 32'(moving), 32'd1);
    tick();
    check_idle("stop2");
    count_high(16, hl, hr);
    check_eq("stop_high_l", 32'(hl), 32'd0);
    check_eq("stop_high_r", 32'(hr), 32'd0);

    // Short pulses from stop must be ignored.
    glitch("glitch3", 3);
    glitch("glitch4", 4);

    // Reset in the middle of a ramp (left duty 8, PWM active).
    do_reset();
    run_to(48);
    state = 2'b00;
    run_to(56);
    check_eq("mid_duty_l", 32'(dut.duty_left), 32'd8);
    check_eq("mid_pwm_l", 32'(pwm_left), 32'd1);
    check_eq("mid_moving", 32'(moving), 32'd1);
    reset = 1'b1;
    state = 2'b10;
    @(posedge clk);
    #1;
    check_idle("mid_rst");
    check_eq("mid_rst_duty", 32'(dut.duty_left), 32'd0);
    check_eq("mid_rst_applied", 32'(dut.applied_left), 32'd0);
    reset = 1'b0;
    cyc   = 0;
    run_to(4); check_eq("re_cmd_e4", 32'(cmd), 32'd3);
    tick();    check_eq("re_cmd_e5", 32'(cmd), 32'd2);
    run_to(7); check_eq("re_duty_e7", 32'(dut.duty_left), 32'd0);
    tick();    check_eq("re_duty_e8", 32'(dut.duty_left), 32'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
